// File: rtl/ufi_ram_responder_if.sv
// UFI request/response bundle between the micro controller master port and a slave.
// Signal names keep the slave-side i/o prefixes so they read the same on both ends.
interface ufi_ram_responder_if #(
   parameter int pUfiBusWidth  = 8,
   parameter int pUfiAdrsWidth = 32
);
   logic [pUfiBusWidth-1:0]  iSUfiWd;
   logic [pUfiAdrsWidth-1:0] iSUfiAdrs;
   logic                     iSUfiWEd;
   logic                     iSUfiREd;
   logic                     iSUfiVd;
   logic                     iSUfiCmd;
   logic                     oSUfiRdy;
   logic [pUfiBusWidth-1:0]  oSUfiRd;
   logic                     oSUfiREd;

   modport master (
      output iSUfiWd, iSUfiAdrs, iSUfiWEd, iSUfiREd, iSUfiVd, iSUfiCmd,
      input  oSUfiRdy, oSUfiRd, oSUfiREd
   );

   modport slave (
      input  iSUfiWd, iSUfiAdrs, iSUfiWEd, iSUfiREd, iSUfiVd, iSUfiCmd,
      output oSUfiRdy, oSUfiRd, oSUfiREd
   );
endinterface

// File: rtl/ufi_ram_responder.sv
// UFI slave that queues requests in an in-order FIFO and replays them against a
// single-port synchronous RAM with a fixed read latency.
module ufi_ram_responder #(
   parameter int          pUfiBusWidth  = 8,
   parameter int          pUfiAdrsWidth = 32,
   parameter logic [2:0]  pSelId        = 3'b001,
   parameter int          pMemAdrsWidth = 19,
   parameter int          pFifoDepth    = 4,
   parameter int          pMemWait      = 2
) (
   input  logic                      iSCLK,
   input  logic                      iSRST,
   ufi_ram_responder_if.slave        ufi,
   output logic [pMemAdrsWidth-1:0]  oMemAdrs,
   output logic [pUfiBusWidth-1:0]   oMemWd,
   output logic                      oMemCe,
   output logic                      oMemWe,
   input  logic [pUfiBusWidth-1:0]   iMemRd,
   output logic                      oBusy
);
   localparam int PtrW  = $clog2(pFifoDepth);
   localparam int CntW  = PtrW + 1;
   localparam int EntW  = 1 + pMemAdrsWidth + pUfiBusWidth;
   localparam int WaitW = (pMemWait > 1) ? $clog2(pMemWait) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [EntW-1:0]          fifo_mem_q [pFifoDepth];
   logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]          count_q, count_d;
   logic [1:0]               state_q, state_d;
   logic [WaitW-1:0]         wait_q, wait_d;
   logic                     op_cmd_q, op_cmd_d;
   logic [pMemAdrsWidth-1:0] op_adrs_q, op_adrs_d;
   logic [pUfiBusWidth-1:0]  op_wd_q, op_wd_d;
   logic [pUfiBusWidth-1:0]  rd_q, rd_d;

   logic            sel;
   logic            rdy;
   logic            accept;
   logic            pop;
   logic [EntW-1:0] push_entry;
   logic [EntW-1:0] head_entry;
   logic            unused_adrs_bits;

   assign sel        = (ufi.iSUfiAdrs[27:25] == pSelId);
   assign rdy        = ~iSRST & (count_q != CntW'(pFifoDepth));
   assign accept     = ufi.iSUfiVd & sel & rdy & (ufi.iSUfiCmd ? ufi.iSUfiREd : ufi.iSUfiWEd);
   assign pop        = (count_q != '0) & ((state_q == ST_IDLE) | (state_q == ST_DONE));
   assign push_entry = {ufi.iSUfiCmd, ufi.iSUfiAdrs[pMemAdrsWidth-1:0], ufi.iSUfiWd};
   assign head_entry = fifo_mem_q[rd_ptr_q];

   // Address bits outside the select field and the RAM window carry no meaning here.
   assign unused_adrs_bits = ^{ufi.iSUfiAdrs[pUfiAdrsWidth-1:28], ufi.iSUfiAdrs[24:pMemAdrsWidth]};

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      op_cmd_d  = op_cmd_q;
      op_adrs_d = op_adrs_q;
      op_wd_d   = op_wd_q;
      rd_d      = rd_q;

      case (state_q)
         ST_IDLE:  if (pop) state_d = ST_ISSUE;
         ST_ISSUE: begin
            wait_d  = WaitW'(pMemWait - 1);
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (wait_q == '0) begin
               if (op_cmd_q) rd_d = iMemRd;
               state_d = ST_DONE;
            end else begin
               wait_d = wait_q - WaitW'(1);
            end
         end
         ST_DONE:  state_d = pop ? ST_ISSUE : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      if (pop) begin
         {op_cmd_d, op_adrs_d, op_wd_d} = head_entry;
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (accept) wr_ptr_d = wr_ptr_q + PtrW'(1);

      // Simultaneous push and pop leave the occupancy unchanged.
      case ({accept, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge iSCLK) begin
      if (iSRST) begin
         state_q   <= ST_IDLE;
         wait_q    <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         op_cmd_q  <= 1'b0;
         op_adrs_q <= '0;
         op_wd_q   <= '0;
         rd_q      <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         op_cmd_q  <= op_cmd_d;
         op_adrs_q <= op_adrs_d;
         op_wd_q   <= op_wd_d;
         rd_q      <= rd_d;
      end
   end

   // Storage is left unreset; occupancy is tracked solely by the pointers and count.
   always_ff @(posedge iSCLK) begin
      if (accept) fifo_mem_q[wr_ptr_q] <= push_entry;
   end

   assign ufi.oSUfiRdy = rdy;
   assign ufi.oSUfiRd  = rd_q;
   assign ufi.oSUfiREd = ~iSRST & (state_q == ST_DONE) & op_cmd_q;
   assign oMemCe       = ~iSRST & (state_q == ST_ISSUE);
   assign oMemWe       = oMemCe & ~op_cmd_q;
   assign oMemAdrs     = op_adrs_q;
   assign oMemWd       = op_wd_q;
   assign oBusy        = ~iSRST & ((count_q != '0) | (state_q != ST_IDLE));
endmodule

// File: tb/tb_ufi_ram_responder.sv
// Directed bench for ufi_ram_responder: vector table plus hand-built multi-cycle sequences.
module tb_ufi_ram_responder;
   logic        clk = 1'b0;
   logic        srst = 1'b1;
   logic [18:0] mem_adrs;
   logic [7:0]  mem_wd;
   logic        mem_ce, mem_we, busy;
   logic [7:0]  mem_rd;
   logic [7:0]  ram [0:(1<<19)-1];
   logic [7:0]  rd_p1, rd_p2;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;

   ufi_ram_responder_if u_if ();

   ufi_ram_responder dut (
      .iSCLK    (clk),
      .iSRST    (srst),
      .ufi      (u_if),
      .oMemAdrs (mem_adrs),
      .oMemWd   (mem_wd),
      .oMemCe   (mem_ce),
      .oMemWe   (mem_we),
      .iMemRd   (mem_rd),
      .oBusy    (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // RAM model: data appears two cycles after the chip-enable cycle.
   always @(posedge clk) begin
      if (mem_ce && mem_we) ram[mem_adrs] <= mem_wd;
      if (mem_ce) rd_p1 <= ram[mem_adrs];
      rd_p2 <= rd_p1;
   end
   assign mem_rd = rd_p2;

   typedef struct { int cyc; logic [18:0] adrs; logic we; logic [7:0] wd; } ce_t;
   typedef struct { int cyc; logic [7:0] d; } red_t;
   typedef struct { bit cmd; logic [31:0] adrs; logic [7:0] wd; } req_t;
   typedef struct { bit cmd; logic [31:0] adrs; logic [7:0] wd; bit sel;
                    logic [18:0] exp_adrs; logic [7:0] exp_rd; } vec_t;

   ce_t  ce_log[$];
   red_t red_log[$];
   req_t bq[$];
   bit   busy_seen;

   always @(negedge clk) begin
      if (mem_ce) ce_log.push_back('{cyc, mem_adrs, mem_we, mem_wd});
      if (u_if.oSUfiREd) red_log.push_back('{cyc, u_if.oSUfiRd});
      if (busy) busy_seen = 1'b1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic drive(input bit cmd, input logic [31:0] a, input logic [7:0] wd, input bit en);
      u_if.iSUfiVd   = 1'b1;
      u_if.iSUfiCmd  = cmd;
      u_if.iSUfiAdrs = a;
      u_if.iSUfiWd   = wd;
      u_if.iSUfiWEd  = en & ~cmd;
      u_if.iSUfiREd  = en & cmd;
   endtask

   task automatic idle_bus();
      u_if.iSUfiVd  = 1'b0;
      u_if.iSUfiWEd = 1'b0;
      u_if.iSUfiREd = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Holds one request until Rdy is seen; acc is the cycle the request was taken.
   task automatic send(input bit cmd, input logic [31:0] a, input logic [7:0] wd, output int acc);
      int guard = 0;
      acc = -1;
      drive(cmd, a, wd, 1'b1);
      while (acc < 0 && guard < 50) begin
         @(negedge clk);
         if (u_if.oSUfiRdy) acc = cyc;
         @(posedge clk); #1;
         guard++;
      end
      idle_bus();
      if (acc < 0) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic burst(output int first_low_after, output int low_cycles);
      int i = 0;
      int guard = 0;
      first_low_after = -1;
      low_cycles = 0;
      while (i < bq.size() && guard < 500) begin
         drive(bq[i].cmd, bq[i].adrs, bq[i].wd, 1'b1);
         @(negedge clk);
         if (u_if.oSUfiRdy) i++;
         else begin
            low_cycles++;
            if (first_low_after < 0) first_low_after = i;
         end
         @(posedge clk); #1;
         guard++;
      end
      idle_bus();
      if (guard >= 500) chk("burst_timeout", 32'd0, 32'd1);
   endtask

   task automatic clear_logs();
      ce_log.delete();
      red_log.delete();
      busy_seen = 1'b0;
   endtask

   vec_t vecs[9];
   int   acc, first_low, low_cnt;

   initial begin
      vecs[0] = '{1'b0, 32'h0200_0010, 8'hA5, 1'b1, 19'h00010, 8'h00};
      vecs[1] = '{1'b1, 32'h0200_0010, 8'h00, 1'b1, 19'h00010, 8'hA5};
      vecs[2] = '{1'b0, 32'h0203_FFFF, 8'h3C, 1'b1, 19'h3FFFF, 8'h00};
      vecs[3] = '{1'b1, 32'h0203_FFFF, 8'h00, 1'b1, 19'h3FFFF, 8'h3C};
      vecs[4] = '{1'b0, 32'hF3F8_0010, 8'h5A, 1'b1, 19'h00010, 8'h00};
      vecs[5] = '{1'b1, 32'h0200_0010, 8'h00, 1'b1, 19'h00010, 8'h5A};
      vecs[6] = '{1'b0, 32'h0400_0010, 8'h77, 1'b0, 19'h00000, 8'h00};
      vecs[7] = '{1'b1, 32'h0800_0010, 8'h00, 1'b0, 19'h00000, 8'h00};
      vecs[8] = '{1'b1, 32'h0200_0010, 8'h00, 1'b1, 19'h00010, 8'h5A};

      idle_bus();
      u_if.iSUfiCmd  = 1'b0;
      u_if.iSUfiAdrs = '0;
      u_if.iSUfiWd   = '0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_rdy_low", {31'd0, u_if.oSUfiRdy}, 32'd0);
      @(posedge clk); #1;
      srst = 1'b0;
      @(negedge clk);
      chk("rst_rdy_after", {31'd0, u_if.oSUfiRdy}, 32'd1);
      chk("rst_outputs", {u_if.oSUfiRd, mem_adrs, mem_wd, u_if.oSUfiREd, mem_ce, mem_we, busy}, 32'd0);
      @(posedge clk); #1;

      for (int v = 0; v < 9; v++) begin
         clear_logs();
         send(vecs[v].cmd, vecs[v].adrs, vecs[v].wd, acc);
         wait_cycles(10);
         if (vecs[v].sel) begin
            chk($sformatf("v%0d_ce_count", v), ce_log.size(), 32'd1);
            if (ce_log.size() > 0) begin
               chk($sformatf("v%0d_ce_cycle", v), ce_log[0].cyc - acc, 32'd2);
               chk($sformatf("v%0d_adrs", v), {13'd0, ce_log[0].adrs}, {13'd0, vecs[v].exp_adrs});
               chk($sformatf("v%0d_we", v), {31'd0, ce_log[0].we}, {31'd0, ~vecs[v].cmd});
               if (!vecs[v].cmd) chk($sformatf("v%0d_wd", v), {24'd0, ce_log[0].wd}, {24'd0, vecs[v].wd});
            end
            chk($sformatf("v%0d_red_count", v), red_log.size(), {31'd0, vecs[v].cmd});
            if (vecs[v].cmd && red_log.size() > 0) begin
               chk($sformatf("v%0d_red_latency", v), red_log[0].cyc - acc, 32'd5);
               chk($sformatf("v%0d_rd", v), {24'd0, red_log[0].d}, {24'd0, vecs[v].exp_rd});
            end
         end else begin
            chk($sformatf("v%0d_desel_ce", v), ce_log.size(), 32'd0);
            chk($sformatf("v%0d_desel_red", v), red_log.size(), 32'd0);
            chk($sformatf("v%0d_desel_busy", v), {31'd0, busy_seen}, 32'd0);
         end
      end

      // Read with REd low must sit unaccepted until REd rises.
      clear_logs();
      drive(1'b1, 32'h0203_FFFF, 8'h00, 1'b0);
      wait_cycles(4);
      chk("noen_ce", ce_log.size(), 32'd0);
      chk("noen_busy", {31'd0, busy_seen}, 32'd0);
      send(1'b1, 32'h0203_FFFF, 8'h00, acc);
      wait_cycles(10);
      chk("en_red_count", red_log.size(), 32'd1);
      if (red_log.size() > 0) chk("en_rd", {24'd0, red_log[0].d}, 32'h3C);

      // Reset while the read is in its WAIT phase.
      clear_logs();
      send(1'b1, 32'h0200_0010, 8'h00, acc);
      wait_cycles(2);
      srst = 1'b1;
      @(negedge clk);
      chk("midrst_ce", {31'd0, mem_ce}, 32'd0);
      chk("midrst_rdy", {31'd0, u_if.oSUfiRdy}, 32'd0);
      @(posedge clk); #1;
      srst = 1'b0;
      @(negedge clk);
      chk("midrst_outputs", {u_if.oSUfiRd, mem_adrs, mem_wd, u_if.oSUfiREd, mem_ce, mem_we, busy}, 32'd0);
      chk("midrst_rdy_back", {31'd0, u_if.oSUfiRdy}, 32'd1);
      wait_cycles(10);
      chk("midrst_no_red", red_log.size(), 32'd0);
      clear_logs();
      send(1'b1, 32'h0200_0010, 8'h00, acc);
      wait_cycles(10);
      chk("postrst_red_count", red_log.size(), 32'd1);
      if (red_log.size() > 0) chk("postrst_rd", {24'd0, red_log[0].d}, 32'h5A);

      // Backpressure: six back-to-back reads into a four-deep FIFO.
      for (int i = 0; i < 6; i++) begin
         send(1'b0, 32'h0200_0020 + i, 8'h80 + 8'(i), acc);
      end
      wait_cycles(30);
      clear_logs();
      bq.delete();
      for (int i = 0; i < 6; i++) bq.push_back('{1'b1, 32'h0200_0020 + i, 8'h00});
      burst(first_low, low_cnt);
      wait_cycles(40);
      chk("bp_first_low_after", first_low, 32'd5);
      chk("bp_low_cycles", low_cnt, 32'd1);
      chk("bp_red_count", red_log.size(), 32'd6);
      for (int i = 0; i < red_log.size() && i < 6; i++) begin
         chk($sformatf("bp_rd%0d", i), {24'd0, red_log[i].d}, 32'h80 + i);
         if (i > 0) chk($sformatf("bp_gap%0d", i), red_log[i].cyc - red_log[i-1].cyc, 32'd4);
      end

      // Continuous mixed stream so pushes line up with pops at full occupancy.
      clear_logs();
      bq.delete();
      for (int k = 0; k < 6; k++) begin
         bq.push_back('{1'b0, 32'h0200_0040 + k, 8'hC0 + 8'(k)});
         bq.push_back('{1'b1, 32'h0200_0040 + k, 8'h00});
      end
      burst(first_low, low_cnt);
      wait_cycles(60);
      chk("pp_ce_count", ce_log.size(), 32'd12);
      chk("pp_red_count", red_log.size(), 32'd6);
      for (int i = 0; i < ce_log.size() && i < 12; i++) begin
         chk($sformatf("pp_adrs%0d", i), {13'd0, ce_log[i].adrs}, 32'h40 + i / 2);
         chk($sformatf("pp_we%0d", i), {31'd0, ce_log[i].we}, {31'd0, ~bq[i].cmd});
      end
      for (int i = 0; i < red_log.size() && i < 6; i++) begin
         chk($sformatf("pp_rd%0d", i), {24'd0, red_log[i].d}, 32'hC0 + i);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
